// File: rtl/lru_pkg.sv
// Shared types, way constants and PLRU access-update rules for the 4-way pseudo-LRU store.
package lru_pkg;

  typedef logic [1:0] way_t;
  typedef logic [2:0] plru_t;

  localparam way_t WAY_A = 2'd0;
  localparam way_t WAY_B = 2'd1;
  localparam way_t WAY_C = 2'd2;
  localparam way_t WAY_D = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } lru_sweep_e;

  // bit2 = victim half, bit1 = victim within c/d, bit0 = victim within a/b
  function automatic plru_t plru_upd_mask(way_t way);
    plru_t mask;
    case (way)
      WAY_A, WAY_B: mask = 3'b101;
      default:      mask = 3'b110;
    endcase
    return mask;
  endfunction

  function automatic plru_t plru_upd_val(way_t way);
    plru_t val;
    case (way)
      WAY_A:   val = 3'b101;
      WAY_B:   val = 3'b100;
      WAY_C:   val = 3'b010;
      default: val = 3'b000;
    endcase
    return val;
  endfunction

  function automatic plru_t plru_touch(plru_t plru, way_t way);
    return (plru & ~plru_upd_mask(way)) | plru_upd_val(way);
  endfunction

endpackage

// File: rtl/lru_victim_array_if.sv
// Controller-side bus of the PLRU victim array: lookups, access commits, invalidates, flush.
interface lru_victim_array_if
  import lru_pkg::*;
#(
  parameter int S_INDEX = 3
);

  logic               rd_req;
  logic [S_INDEX-1:0] rd_index;
  logic               rd_ready;
  logic               rd_valid;
  way_t               victim_way;
  logic [3:0]         victim_oh;
  logic               upd_en;
  logic [S_INDEX-1:0] upd_index;
  way_t               upd_way;
  logic               inv_en;
  logic [S_INDEX-1:0] inv_index;
  way_t               inv_way;
  logic               flush;
  logic               busy;

  modport master (
    output rd_req, rd_index, upd_en, upd_index, upd_way,
           inv_en, inv_index, inv_way, flush,
    input  rd_ready, rd_valid, victim_way, victim_oh, busy
  );

  modport slave (
    input  rd_req, rd_index, upd_en, upd_index, upd_way,
           inv_en, inv_index, inv_way, flush,
    output rd_ready, rd_valid, victim_way, victim_oh, busy
  );

endinterface

// File: rtl/lru_victim_sel.sv
// Victim decode for one set: lowest invalid way first, otherwise follow the PLRU tree.
module lru_victim_sel
  import lru_pkg::*;
(
  input  plru_t      plru,
  input  logic [3:0] valid,
  output way_t       way,
  output logic [3:0] way_oh
);

  always_comb begin
    way = WAY_A;
    if (!valid[0])      way = WAY_A;
    else if (!valid[1]) way = WAY_B;
    else if (!valid[2]) way = WAY_C;
    else if (!valid[3]) way = WAY_D;
    else if (!plru[2])  way = plru[0] ? WAY_B : WAY_A;
    else                way = plru[1] ? WAY_D : WAY_C;
    way_oh = 4'b0001 << way;
  end

endmodule

// File: rtl/lru_victim_array.sv
// Per-set PLRU + valid storage with registered victim lookup and a one-set-per-cycle flush sweep.
// Define LRU_BYPASS_EN to forward same-cycle updates into the lookup path.
module lru_victim_array
  import lru_pkg::*;
#(
  parameter int S_INDEX  = 3,
  parameter int LRU_BITS = 3
)(
  input  logic              clk,
  input  logic              rst,
  lru_victim_array_if.slave bus
);

  localparam int NSETS = 1 << S_INDEX;

  if (LRU_BITS != 3) begin : g_bad_lru_bits
    $error("lru_victim_array: LRU_BITS must be 3 for a 4-way PLRU");
  end

  lru_sweep_e         state_q, state_d;
  logic [S_INDEX-1:0] cnt_q, cnt_d;

  plru_t      plru_q  [NSETS];
  plru_t      plru_d  [NSETS];
  logic [3:0] valid_q [NSETS];
  logic [3:0] valid_d [NSETS];

  plru_t      sel_plru;
  logic [3:0] sel_valid;
  way_t       sel_way;
  logic [3:0] sel_oh;
  logic       rd_accept;

  logic       rd_valid_q;
  way_t       victim_way_q;
  logic [3:0] victim_oh_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        cnt_d = cnt_q + S_INDEX'(1);
        if (cnt_q == S_INDEX'(NSETS - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Invalidate is applied before the access commit so a same-way collision ends valid.
  always_comb begin
    for (int s = 0; s < NSETS; s++) begin
      plru_d[s]  = plru_q[s];
      valid_d[s] = valid_q[s];
      if (state_q == SWEEP) begin
        if (cnt_q == S_INDEX'(s)) begin
          plru_d[s]  = '0;
          valid_d[s] = '0;
        end
      end else begin
        if (bus.inv_en && bus.inv_index == S_INDEX'(s))
          valid_d[s][bus.inv_way] = 1'b0;
        if (bus.upd_en && bus.upd_index == S_INDEX'(s)) begin
          valid_d[s][bus.upd_way] = 1'b1;
          plru_d[s]               = plru_touch(plru_q[s], bus.upd_way);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      for (int s = 0; s < NSETS; s++) begin
        plru_q[s]  <= '0;
        valid_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int s = 0; s < NSETS; s++) begin
        plru_q[s]  <= plru_d[s];
        valid_q[s] <= valid_d[s];
      end
    end
  end

`ifdef LRU_BYPASS_EN
  assign sel_plru  = plru_d[bus.rd_index];
  assign sel_valid = valid_d[bus.rd_index];
`else
  assign sel_plru  = plru_q[bus.rd_index];
  assign sel_valid = valid_q[bus.rd_index];
`endif

  lru_victim_sel u_sel (
    .plru   (sel_plru),
    .valid  (sel_valid),
    .way    (sel_way),
    .way_oh (sel_oh)
  );

  assign rd_accept = bus.rd_req && (state_q == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q   <= 1'b0;
      victim_way_q <= WAY_A;
      victim_oh_q  <= 4'b0001;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        victim_way_q <= sel_way;
        victim_oh_q  <= sel_oh;
      end
    end
  end

  assign bus.rd_valid   = rd_valid_q;
  assign bus.victim_way = victim_way_q;
  assign bus.victim_oh  = victim_oh_q;
  assign bus.rd_ready   = (state_q == IDLE);
  assign bus.busy       = (state_q == SWEEP);

endmodule

// File: tb/tb_lru_victim_array.sv
// Self-checking bench for lru_victim_array: vector table, directed corner sequences, random traffic.
module tb_lru_victim_array;
  import lru_pkg::*;

  localparam int S_INDEX = 3;
  localparam int NSETS   = 1 << S_INDEX;
`ifdef LRU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lru_victim_array_if #(.S_INDEX(S_INDEX)) bus ();

  lru_victim_array #(.S_INDEX(S_INDEX), .LRU_BITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Recency model: which half and which way inside each half was touched last.
  bit m_valid     [NSETS][4];
  int m_last_half [NSETS];
  int m_last_ab   [NSETS];
  int m_last_cd   [NSETS];
  int m_left;
  int m_idx;
  int m_way;

  typedef struct {
    bit upd_en; int upd_idx; int upd_way;
    bit inv_en; int inv_idx; int inv_way;
    bit rd;     int rd_idx;  int exp_way;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void m_clear_set(int s);
    for (int w = 0; w < 4; w++) m_valid[s][w] = 1'b0;
    m_last_half[s] = 1;
    m_last_ab[s]   = 1;
    m_last_cd[s]   = 3;
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NSETS; s++) m_clear_set(s);
    m_left = 0;
    m_idx  = 0;
    m_way  = 0;
  endfunction

  function automatic void m_touch(int s, int w);
    m_valid[s][w]  = 1'b1;
    m_last_half[s] = w / 2;
    if (w < 2) m_last_ab[s] = w;
    else       m_last_cd[s] = w;
  endfunction

  function automatic int m_victim(int s);
    for (int w = 0; w < 4; w++) if (!m_valid[s][w]) return w;
    if (m_last_half[s] == 1) return 1 - m_last_ab[s];
    return 5 - m_last_cd[s];
  endfunction

  task automatic idle_inputs();
    bus.rd_req = 0; bus.rd_index = '0;
    bus.upd_en = 0; bus.upd_index = '0; bus.upd_way = WAY_A;
    bus.inv_en = 0; bus.inv_index = '0; bus.inv_way = WAY_A;
    bus.flush  = 0;
  endtask

  // One clock with whatever is currently driven; model advances alongside the DUT.
  task automatic step();
    bit acc;
    int exp_rd;
    exp_rd = m_way;
    chk("rd_ready", bus.rd_ready, (m_left == 0));
    chk("busy", bus.busy, (m_left != 0));
    acc = bus.rd_req && (m_left == 0);
    if (acc && !BYPASS) exp_rd = m_victim(int'(bus.rd_index));
    if (m_left > 0) begin
      m_clear_set(m_idx);
      m_idx++;
      m_left--;
    end else begin
      if (bus.inv_en) m_valid[int'(bus.inv_index)][int'(bus.inv_way)] = 1'b0;
      if (bus.upd_en) m_touch(int'(bus.upd_index), int'(bus.upd_way));
      if (bus.flush) begin
        m_left = NSETS;
        m_idx  = 0;
      end
    end
    if (acc && BYPASS) exp_rd = m_victim(int'(bus.rd_index));
    @(posedge clk);
    #1;
    chk("rd_valid", bus.rd_valid, acc);
    if (acc) m_way = exp_rd;
    chk("victim_way", bus.victim_way, m_way);
    chk("victim_oh", bus.victim_oh, 32'(1) << m_way);
  endtask

  task automatic do_upd(int s, int w);
    idle_inputs();
    bus.upd_en = 1; bus.upd_index = S_INDEX'(s); bus.upd_way = way_t'(w);
    step();
  endtask

  task automatic do_read(int s);
    idle_inputs();
    bus.rd_req = 1; bus.rd_index = S_INDEX'(s);
    step();
  endtask

  task automatic apply_reset();
    rst = 1;
    idle_inputs();
    @(posedge clk);
    #1;
    m_reset();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    m_reset();
    @(posedge clk);
    #1;
    chk("reset rd_valid", bus.rd_valid, 0);
    chk("reset victim_way", bus.victim_way, 0);
    chk("reset victim_oh", bus.victim_oh, 4'b0001);
    chk("reset busy", bus.busy, 0);
    chk("reset rd_ready", bus.rd_ready, 1);
    rst = 0;

    do_read(0);
    chk("post-reset read set0", bus.victim_way, 0);

    // upd_en, upd_idx, upd_way, inv_en, inv_idx, inv_way, rd, rd_idx, exp_way
    tbl.push_back('{1, 2, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 2, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 2, 0});
    tbl.push_back('{1, 5, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 5, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 5, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 5, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 5, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 5, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 5, 1});
    tbl.push_back('{0, 0, 0, 1, 5, 3, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 5, 3});
    tbl.push_back('{1, 6, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 6, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 6, 2, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 6, 3, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 6, 1, 1, 6, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 6, 2});
    tbl.push_back('{1, 6, 3, 1, 6, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 6, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      idle_inputs();
      bus.upd_en = tbl[i].upd_en; bus.upd_index = S_INDEX'(tbl[i].upd_idx);
      bus.upd_way = way_t'(tbl[i].upd_way);
      bus.inv_en = tbl[i].inv_en; bus.inv_index = S_INDEX'(tbl[i].inv_idx);
      bus.inv_way = way_t'(tbl[i].inv_way);
      bus.rd_req = tbl[i].rd; bus.rd_index = S_INDEX'(tbl[i].rd_idx);
      step();
      if (tbl[i].rd) chk($sformatf("table[%0d] victim", i), bus.victim_way, tbl[i].exp_way);
    end

    // Same-cycle access and lookup on a full set with PLRU cleared.
    for (int w = 0; w < 4; w++) do_upd(1, w);
    idle_inputs();
    bus.upd_en = 1; bus.upd_index = 3'd1; bus.upd_way = WAY_A;
    bus.rd_req = 1; bus.rd_index = 3'd1;
    step();
    chk("same-cycle upd+rd", bus.victim_way, BYPASS ? 2 : 0);
    idle_inputs();
    step();
    chk("rd_valid one pulse", bus.rd_valid, 0);
    chk("victim held", bus.victim_way, BYPASS ? 2 : 0);

    // Flush with a read accepted in the flush cycle, then blocked traffic during the sweep.
    idle_inputs();
    bus.flush = 1; bus.rd_req = 1; bus.rd_index = 3'd5;
    step();
    chk("read in flush cycle", bus.victim_way, 3);
    for (int c = 0; c < NSETS; c++) begin
      idle_inputs();
      bus.rd_req = 1; bus.rd_index = S_INDEX'(c);
      bus.upd_en = 1; bus.upd_index = S_INDEX'(c); bus.upd_way = WAY_B;
      bus.flush  = (c == 2);
      chk($sformatf("sweep busy c%0d", c), bus.busy, 1);
      step();
      chk($sformatf("sweep no rd_valid c%0d", c), bus.rd_valid, 0);
    end
    chk("busy after sweep", bus.busy, 0);
    chk("rd_ready after sweep", bus.rd_ready, 1);
    for (int s = 0; s < NSETS; s++) begin
      do_read(s);
      chk($sformatf("post-flush set%0d", s), bus.victim_way, 0);
    end

    // Reset in the middle of a sweep.
    for (int w = 0; w < 4; w++) do_upd(7, w);
    do_upd(7, 0);
    do_read(7);
    chk("set7 before flush", bus.victim_way, 2);
    idle_inputs();
    bus.flush = 1;
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) step();
    #2;
    rst = 1;
    #1;
    m_reset();
    chk("mid-sweep rst busy", bus.busy, 0);
    chk("mid-sweep rst rd_ready", bus.rd_ready, 1);
    chk("mid-sweep rst rd_valid", bus.rd_valid, 0);
    chk("mid-sweep rst victim_oh", bus.victim_oh, 4'b0001);
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    do_read(7);
    chk("read after mid-sweep rst", bus.victim_way, 0);

    // Random traffic against the recency model.
    for (int c = 0; c < 600; c++) begin
      idle_inputs();
      bus.rd_req    = 1'($urandom_range(0, 1));
      bus.rd_index  = S_INDEX'($urandom_range(0, NSETS - 1));
      bus.upd_en    = ($urandom_range(0, 9) < 6);
      bus.upd_index = S_INDEX'($urandom_range(0, NSETS - 1));
      bus.upd_way   = way_t'($urandom_range(0, 3));
      bus.inv_en    = ($urandom_range(0, 9) < 3);
      bus.inv_index = ($urandom_range(0, 1) == 1) ? bus.upd_index
                                                 : S_INDEX'($urandom_range(0, NSETS - 1));
      bus.inv_way   = way_t'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.rd_index = bus.upd_index;
      bus.flush     = ($urandom_range(0, 79) == 0);
      step();
    end

    idle_inputs();
    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
